// File: rtl/fifo_level_if.sv
// Push/pop valid-grant handshake bundle for fifo_level.
// slave is the FIFO side, master is the producer/consumer side.
interface fifo_level_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  push_valid_i;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic                  push_grant_o;
  logic                  pop_valid_o;
  logic [DATA_WIDTH-1:0] pop_data_o;
  logic                  pop_grant_i;

  modport master (
    output push_valid_i,
    output push_data_i,
    output pop_grant_i,
    input  push_grant_o,
    input  pop_valid_o,
    input  pop_data_o
  );

  modport slave (
    input  push_valid_i,
    input  push_data_i,
    input  pop_grant_i,
    output push_grant_o,
    output pop_valid_o,
    output pop_data_o
  );
endinterface

// File: rtl/fifo_level.sv
// Any-depth valid/grant FIFO with level, almost flags, flush, sticky underflow.
// Define FIFO_LEVEL_BYPASS_EN for zero-latency fall-through when empty.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  fifo_level_if.slave                fif,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic                       underflow_o
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  pass;
  logic                  wr_en;
  logic                  rd_en;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  assign fif.push_grant_o = !full && !flush_i;

`ifdef FIFO_LEVEL_BYPASS_EN
  // Empty FIFO falls through; a taken word never touches storage.
  assign pass = empty && !flush_i
             && fif.push_valid_i && fif.pop_grant_i;

  always_comb begin
    fif.pop_valid_o = 1'b0;
    fif.pop_data_o  = '0;
    if (!flush_i) begin
      if (empty) begin
        fif.pop_valid_o = fif.push_valid_i;
        if (fif.push_valid_i)
          fif.pop_data_o = fif.push_data_i;
      end else begin
        fif.pop_valid_o = 1'b1;
        fif.pop_data_o  = mem[rd_ptr];
      end
    end
  end
`else
  assign pass = 1'b0;

  always_comb begin
    fif.pop_valid_o = !empty && !flush_i;
    fif.pop_data_o  = '0;
    if (fif.pop_valid_o)
      fif.pop_data_o = mem[rd_ptr];
  end
`endif

  assign push_fire = fif.push_valid_i && fif.push_grant_o;
  assign pop_fire  = fif.pop_valid_o && fif.pop_grant_i;
  assign wr_en     = push_fire && !pass;
  assign rd_en     = pop_fire && !pass;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= fif.push_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= nxt(wr_ptr);
      if (rd_en)
        rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        wr_en && !rd_en: level <= level + 1'b1;
        rd_en && !wr_en: level <= level - 1'b1;
        default:         level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underflow_o <= 1'b0;
    else if (fif.pop_grant_i && !fif.pop_valid_o)
      underflow_o <= 1'b1;
  end

  assign level_o        = level;
  assign almost_full_o  = (level >= LW'(AF_THRESH));
  assign almost_empty_o = (level <= LW'(AE_THRESH));
endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: DEPTH=4 and DEPTH=3 instances share one stimulus,
// each checked every cycle against a queue model plus literal expectations.
module tb_fifo_level;
  logic       clk;
  logic       rst_n;
  logic       fl;
  logic       pv;
  logic       pg;
  logic [7:0] pd;

  logic [2:0] lvl4;
  logic [1:0] lvl3;
  logic       af4, ae4, uf4;
  logic       af3, ae3, uf3;

  int checks = 0;
  int errors = 0;

  fifo_level_if #(.DATA_WIDTH(8)) if4 ();
  fifo_level_if #(.DATA_WIDTH(8)) if3 ();

  assign if4.push_valid_i = pv;
  assign if4.push_data_i  = pd;
  assign if4.pop_grant_i  = pg;
  assign if3.push_valid_i = pv;
  assign if3.push_data_i  = pd;
  assign if3.pop_grant_i  = pg;

  fifo_level #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
    .clk            (clk),
    .reset_n        (rst_n),
    .flush_i        (fl),
    .fif            (if4),
    .level_o        (lvl4),
    .almost_full_o  (af4),
    .almost_empty_o (ae4),
    .underflow_o    (uf4)
  );

  fifo_level #(.DATA_WIDTH(8), .DEPTH(3)) u3 (
    .clk            (clk),
    .reset_n        (rst_n),
    .flush_i        (fl),
    .fif            (if3),
    .level_o        (lvl3),
    .almost_full_o  (af3),
    .almost_empty_o (ae3),
    .underflow_o    (uf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: index 0 is DEPTH=4, index 1 is DEPTH=3.
  logic [7:0] q [2][$];
  logic       muf [2] = '{1'b0, 1'b0};

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      muf[k] = 1'b0;
    end
  endtask

  task automatic mstep();
    int dep;
    int sz;
    bit pgo;
    bit pvo;
    bit pass;
    for (int k = 0; k < 2; k++) begin
      dep  = (k == 0) ? 4 : 3;
      sz   = q[k].size();
      pgo  = (sz != dep) && !fl;
      pvo  = (sz != 0) && !fl;
      pass = 1'b0;
`ifdef FIFO_LEVEL_BYPASS_EN
      if (sz == 0 && !fl) begin
        pvo  = pv;
        pass = pv && pg;
      end
`endif
      if (pg && !pvo)
        muf[k] = 1'b1;
      if (fl)
        q[k].delete();
      else if (!pass) begin
        if (pvo && pg)
          void'(q[k].pop_front());
        if (pv && pgo)
          q[k].push_back(pd);
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mreset();
    else
      mstep();
  end

  task automatic cmp(input int k, input logic a_pg, input logic a_pv,
                     input logic [7:0] a_pd, input int a_lv,
                     input logic a_af, input logic a_ae,
                     input logic a_uf);
    int         dep;
    int         sz;
    logic       e_pv;
    logic [7:0] e_pd;
    string      p;
    dep  = (k == 0) ? 4 : 3;
    sz   = q[k].size();
    p    = $sformatf("D%0d_", dep);
    e_pv = (sz != 0) && !fl;
    e_pd = 8'h00;
    if (e_pv)
      e_pd = q[k][0];
`ifdef FIFO_LEVEL_BYPASS_EN
    if (sz == 0 && !fl) begin
      e_pv = pv;
      e_pd = pv ? pd : 8'h00;
    end
`endif
    chk({p, "push_grant"}, int'(a_pg), int'((sz != dep) && !fl));
    chk({p, "pop_valid"}, int'(a_pv), int'(e_pv));
    chk({p, "pop_data"}, int'(a_pd), int'(e_pd));
    chk({p, "level"}, a_lv, sz);
    chk({p, "almost_full"}, int'(a_af), int'(sz >= dep - 1));
    chk({p, "almost_empty"}, int'(a_ae), int'(sz <= 1));
    chk({p, "underflow"}, int'(a_uf), int'(muf[k]));
  endtask

  always @(negedge clk) begin
    cmp(0, if4.push_grant_o, if4.pop_valid_o, if4.pop_data_o,
        int'(lvl4), af4, ae4, uf4);
    cmp(1, if3.push_grant_o, if3.pop_valid_o, if3.pop_data_o,
        int'(lvl3), af3, ae3, uf3);
  end

  task automatic step(input logic f, input logic v,
                      input logic [7:0] d, input logic g);
    fl = f;
    pv = v;
    pd = d;
    pg = g;
    @(posedge clk);
    #1;
    fl = 1'b0;
    pv = 1'b0;
    pd = 8'h00;
    pg = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    fl    = 1'b0;
    pv    = 1'b0;
    pd    = 8'h00;
    pg    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    chk("rst_level", int'(lvl4), 0);
    chk("rst_pop_valid", int'(if4.pop_valid_o), 0);
    chk("rst_push_grant", int'(if4.push_grant_o), 1);
    chk("rst_almost_empty", int'(ae4), 1);
    chk("rst_almost_full", int'(af4), 0);
    chk("rst_underflow", int'(uf4), 0);

    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      step(1'b0, 1'b1, v, 1'b0);
      chk("fill_level", int'(lvl4), i + 1);
      chk("fill_af", int'(af4), int'(i >= 2));
    end
    chk("full_grant", int'(if4.push_grant_o), 0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    chk("held_level4", int'(lvl4), 4);
    chk("held_level3", int'(lvl3), 3);

    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      chk("drain_data", int'(if4.pop_data_o), int'(v));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_level", int'(lvl4), 0);
    chk("drain_uf4", int'(uf4), 0);
    chk("drain_uf3", int'(uf3), 1);

    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    for (int i = 3; i <= 10; i++) begin
      chk("wrap_head", int'(if3.pop_data_o), i - 2);
      step(1'b0, 1'b1, 8'(i), 1'b1);
      chk("wrap_level", int'(lvl3), 2);
      chk("wrap_not_full", int'(if3.push_grant_o), 1);
    end

    chk("pp_head", int'(if4.pop_data_o), 8'h09);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("pp_level", int'(lvl4), 2);
    chk("pp_next", int'(if4.pop_data_o), 8'h0A);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pp_a5_4", int'(if4.pop_data_o), 8'hA5);
    chk("pp_a5_3", int'(if3.pop_data_o), 8'hA5);

    step(1'b0, 1'b1, 8'hB1, 1'b0);
    step(1'b0, 1'b1, 8'hB2, 1'b0);
    chk("pre_flush", int'(lvl4), 3);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("flush_level4", int'(lvl4), 0);
    chk("flush_level3", int'(lvl3), 0);
    chk("flush_valid", int'(if4.pop_valid_o), 0);
    step(1'b0, 1'b1, 8'h12, 1'b0);
    chk("flush_no77", int'(if4.pop_data_o), 8'h12);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    chk("uf_before", int'(uf4), 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("uf_set", int'(uf4), 1);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("uf_sticky", int'(uf4), 1);
    rst_n = 1'b0;
    #2;
    chk("uf_rst4", int'(uf4), 0);
    chk("uf_rst3", int'(uf3), 0);
    chk("rst_mid_level", int'(lvl4), 0);
    rst_n = 1'b1;
    #1;

`ifdef FIFO_LEVEL_BYPASS_EN
    fl = 1'b0;
    pv = 1'b1;
    pd = 8'h3C;
    pg = 1'b1;
    #1;
    chk("byp_valid", int'(if4.pop_valid_o), 1);
    chk("byp_data", int'(if4.pop_data_o), 8'h3C);
    @(posedge clk);
    #1;
    pv = 1'b0;
    pd = 8'h00;
    pg = 1'b0;
    #1;
    chk("byp_level", int'(lvl4), 0);
`else
    fl = 1'b0;
    pv = 1'b1;
    pd = 8'h3C;
    pg = 1'b0;
    #1;
    chk("reg_valid0", int'(if4.pop_valid_o), 0);
    @(posedge clk);
    #1;
    pv = 1'b0;
    pd = 8'h00;
    #1;
    chk("reg_level", int'(lvl4), 1);
    chk("reg_data", int'(if4.pop_data_o), 8'h3C);
`endif
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
